// File: rtl/regfile_multiport.sv
// regfile_multiport: DEPTH x WIDTH flop-based register file, one write port, NUM_RD registered read ports.
// Optional macro REGFILE_WR_BYPASS_EN selects write-first forwarding on same-edge read/write collisions.

module regfile_rd_port #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] data,
    output logic             valid
);
    // Data holds its last value when the port is idle; only valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= en;
            if (en) data <= word;
        end
    end
endmodule

module regfile_multiport #(
    parameter  int WIDTH     = 32,
    parameter  int DEPTH     = 32,
    parameter  int NUM_RD    = 2,
    parameter  int ZERO_REG0 = 1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    wr_en_i,
    input  logic [AW-1:0]           wr_addr_i,
    input  logic [WIDTH-1:0]        wr_data_i,
    input  logic [NUM_RD-1:0]       rd_en_i,
    input  logic [NUM_RD*AW-1:0]    rd_addr_i,
    output logic [NUM_RD*WIDTH-1:0] rd_data_o,
    output logic [NUM_RD-1:0]       rd_valid_o
);
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic                        wr_ok;

    // Writes to register 0 are dropped when it is hardwired to zero.
    assign wr_ok = wr_en_i && !((ZERO_REG0 != 0) && (wr_addr_i == '0));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) mem <= '0;
        else if (wr_ok) mem[wr_addr_i] <= wr_data_i;
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] word;

        assign addr = rd_addr_i[p*AW +: AW];

        always_comb begin
            word = mem[addr];
`ifdef REGFILE_WR_BYPASS_EN
            if (wr_ok && (wr_addr_i == addr)) word = wr_data_i;
`endif
            // Zero override wins over forwarding.
            if ((ZERO_REG0 != 0) && (addr == '0)) word = '0;
        end

        regfile_rd_port #(.WIDTH(WIDTH)) u_port (
            .clk   (clk_i),
            .rst_n (rst_n_i),
            .en    (rd_en_i[p]),
            .word  (word),
            .data  (rd_data_o[p*WIDTH +: WIDTH]),
            .valid (rd_valid_o[p])
        );
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: vector table on a 32x32/2-port instance, scoreboard sweep on a 16x8/4-port one.
module tb_regfile_multiport;
`ifdef REGFILE_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance 1: defaults (WIDTH 32, DEPTH 32, NUM_RD 2, ZERO_REG0 1)
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [1:0]  rd_en = '0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_valid;

    regfile_multiport dut (
        .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid)
    );

    // Instance 2: 4 ports, 16 x 8, register 0 ordinary
    logic        w2_en = 1'b0;
    logic [3:0]  w2_addr = '0;
    logic [7:0]  w2_data = '0;
    logic [3:0]  r2_en = '0;
    logic [15:0] r2_addr = '0;
    logic [31:0] r2_data;
    logic [3:0]  r2_valid;

    regfile_multiport #(.WIDTH(8), .DEPTH(16), .NUM_RD(4), .ZERO_REG0(0)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(w2_en), .wr_addr_i(w2_addr), .wr_data_i(w2_data),
        .rd_en_i(r2_en), .rd_addr_i(r2_addr), .rd_data_o(r2_data), .rd_valid_o(r2_valid)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  en;
        logic [4:0]  a0, a1;
        logic [1:0]  ev;
        logic [31:0] e0, e1;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                                input logic [1:0] ev, input logic [31:0] e0, input logic [31:0] e1);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.en = en; v.a0 = a0; v.a1 = a1;
        v.ev = ev; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    // Reference model and scoreboard for instance 2
    logic [7:0] m2 [16];
    logic [9:0] sbq [$];   // {port[1:0], data[7:0]}

    task automatic cycle2(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                          input logic [3:0] en, input logic [15:0] ad);
        logic [3:0] a;
        logic [7:0] e;
        logic [9:0] got;
        @(negedge clk);
        w2_en = we; w2_addr = wa; w2_data = wd; r2_en = en; r2_addr = ad;
        for (int p = 0; p < 4; p++) begin
            if (en[p]) begin
                a = ad[p*4 +: 4];
                e = m2[a];
                if (BYP && we && (wa == a)) e = wd;
                sbq.push_back({2'(p), e});
            end
        end
        if (we) m2[wa] = wd;
        @(posedge clk); #1;
        check("sweep valid", 64'(r2_valid), 64'(en));
        for (int p = 0; p < 4; p++) begin
            if (r2_valid[p]) begin
                if (sbq.size() == 0) begin
                    check("sweep sb underflow", 64'(1), 64'(0));
                end else begin
                    got = {2'(p), r2_data[p*8 +: 8]};
                    check($sformatf("sweep port%0d addr%0d", p, ad[p*4 +: 4]), 64'(got), 64'(sbq.pop_front()));
                end
            end
        end
    endtask

    vec_t vt [15];

    initial begin
        logic [31:0] col6, col14;
        logic [15:0] ad;
        col6  = BYP ? 32'h2 : 32'h1;
        col14 = BYP ? 32'hDEADBEEF : 32'h0;
        //          we  wa     wd            en     a0     a1     ev     e0            e1
        vt[0]  = mk(1, 5'd1,  32'h11111111, 2'b00, 5'd0,  5'd0,  2'b00, 32'h0,        32'h0);
        vt[1]  = mk(1, 5'd31, 32'hFFFF0000, 2'b00, 5'd0,  5'd0,  2'b00, 32'h0,        32'h0);
        vt[2]  = mk(0, 5'd0,  32'h0,        2'b11, 5'd1,  5'd31, 2'b11, 32'h11111111, 32'hFFFF0000);
        vt[3]  = mk(1, 5'd0,  32'hA5A5A5A5, 2'b00, 5'd0,  5'd0,  2'b00, 32'h11111111, 32'hFFFF0000);
        vt[4]  = mk(0, 5'd0,  32'h0,        2'b11, 5'd0,  5'd0,  2'b11, 32'h0,        32'h0);
        vt[5]  = mk(1, 5'd7,  32'h1,        2'b01, 5'd1,  5'd0,  2'b01, 32'h11111111, 32'h0);
        vt[6]  = mk(1, 5'd7,  32'h2,        2'b11, 5'd7,  5'd7,  2'b11, col6,         col6);
        vt[7]  = mk(0, 5'd0,  32'h0,        2'b11, 5'd7,  5'd7,  2'b11, 32'h2,        32'h2);
        vt[8]  = mk(1, 5'd3,  32'h33,       2'b00, 5'd0,  5'd0,  2'b00, 32'h2,        32'h2);
        vt[9]  = mk(0, 5'd0,  32'h0,        2'b11, 5'd3,  5'd1,  2'b11, 32'h33,       32'h11111111);
        vt[10] = mk(0, 5'd0,  32'h0,        2'b00, 5'd3,  5'd1,  2'b00, 32'h33,       32'h11111111);
        vt[11] = mk(0, 5'd0,  32'h0,        2'b00, 5'd3,  5'd1,  2'b00, 32'h33,       32'h11111111);
        vt[12] = mk(0, 5'd0,  32'h0,        2'b00, 5'd3,  5'd1,  2'b00, 32'h33,       32'h11111111);
        vt[13] = mk(1, 5'd0,  32'h0000DEAD, 2'b11, 5'd0,  5'd0,  2'b11, 32'h0,        32'h0);
        vt[14] = mk(1, 5'd5,  32'hDEADBEEF, 2'b10, 5'd0,  5'd5,  2'b10, 32'h0,        col14);
        for (int i = 0; i < 16; i++) m2[i] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset valid", 64'(rd_valid), 64'(0));
        check("reset data", rd_data, 64'(0));
        check("reset dut2", {28'(0), r2_valid, r2_data}, 64'(0));
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
            rd_en = vt[i].en; rd_addr = {vt[i].a1, vt[i].a0};
            @(posedge clk); #1;
            check($sformatf("vec%0d valid", i), 64'(rd_valid), 64'(vt[i].ev));
            check($sformatf("vec%0d data", i), rd_data, {vt[i].e1, vt[i].e0});
        end

        // Mid-cycle asynchronous reset with reads in flight and a write held across reset
        @(negedge clk);
        wr_en = 1'b0; rd_en = 2'b11; rd_addr = {5'd1, 5'd5};
        @(posedge clk); #1;
        check("pre-reset data", rd_data, {32'h11111111, 32'hDEADBEEF});
        #2;
        rst_n = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678;
        #1;
        check("async reset valid", 64'(rd_valid), 64'(0));
        check("async reset data", rd_data, 64'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1'b0; rd_en = 2'b11; rd_addr = {5'd1, 5'd5};
        @(posedge clk); #1;
        check("post-reset valid", 64'(rd_valid), 64'(3));
        check("post-reset r5/r1", rd_data, 64'(0));
        @(negedge clk) rd_en = 2'b00;

        // Instance 2: write i^0x5A while reading rotating addresses (port 0 collides)
        for (int i = 0; i < 16; i++) begin
            for (int p = 0; p < 4; p++) ad[p*4 +: 4] = 4'(i + 4*p);
            cycle2(1'b1, 4'(i), 8'(i) ^ 8'h5A, 4'hF, ad);
        end
        for (int c = 0; c < 16; c++) begin
            for (int p = 0; p < 4; p++) ad[p*4 +: 4] = 4'(c + 5*p);
            cycle2(1'b0, 4'd0, 8'h00, 4'hF, ad);
        end
        // Register 0 is ordinary here: collision then plain read
        cycle2(1'b1, 4'd0, 8'hA5, 4'hF, 16'h0000);
        cycle2(1'b0, 4'd0, 8'h00, 4'hF, 16'h0000);
        for (int k = 0; k < 40; k++) begin
            cycle2(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
                   4'($urandom_range(0, 15)), 16'($urandom));
        end
        check("sb drained", 64'(sbq.size()), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
